// File: rtl/lif_neuron_multi.sv
// Leaky integrate-and-fire neuron with N_IN weighted synapses, saturating
// signed fixed-point membrane potential, refractory period and spike counter.
module lif_neuron_multi #(
  parameter int W          = 8,
  parameter int FRACT      = 4,
  parameter int N_IN       = 4,
  parameter int LAMBDA     = 12,
  parameter int THRESH     = 16,
  parameter int REFRAC     = 2,
  parameter int RESET_MODE = 0,
  parameter int CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [N_IN-1:0]       in_spk,
  input  logic [N_IN*W-1:0]     weights,
  input  logic                  clr_cnt,
  output logic                  s_out,
  output logic signed [W-1:0]   p_out,
  output logic                  refrac,
  output logic [CNT_W-1:0]      spike_cnt
);

  // Internal width holds the full leak product plus the synaptic sum without overflow.
  localparam int AW = 2 * W + $clog2(N_IN) + 2;
  localparam int RW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;

  localparam logic signed [W-1:0]  LAM_W  = W'(LAMBDA);
  localparam logic signed [W-1:0]  THR_W  = W'(THRESH);
  localparam logic signed [AW-1:0] SAT_HI = AW'((1 << (W - 1)) - 1);
  localparam logic signed [AW-1:0] SAT_LO = ~SAT_HI;
  localparam logic [CNT_W-1:0]     CNT_MAX = '1;

  // Valid handshake: none; every en=1 edge is one timestep, outputs are registered.

  function automatic logic signed [AW-1:0] sext(input logic [W-1:0] x);
    return {{(AW - W){x[W-1]}}, x};
  endfunction

  function automatic logic signed [W-1:0] sat(input logic signed [AW-1:0] x);
    if (x > SAT_HI) return SAT_HI[W-1:0];
    if (x < SAT_LO) return SAT_LO[W-1:0];
    return x[W-1:0];
  endfunction

  logic signed [W-1:0]  p_q;
  logic [RW-1:0]        rcnt;
  logic signed [AW-1:0] leak;
  logic signed [AW-1:0] syn;
  logic signed [W-1:0]  leak_sat;
  logic signed [W-1:0]  v_sat;
  logic                 fire;

  always_comb begin
    leak = (sext(LAM_W) * sext(p_q)) >>> FRACT;
    syn  = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (in_spk[i]) syn = syn + sext(weights[i*W +: W]);
    end
    leak_sat = sat(leak);
    v_sat    = sat(leak + syn);
    fire     = (rcnt == '0) && (v_sat >= THR_W);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_q       <= '0;
      rcnt      <= '0;
      s_out     <= 1'b0;
      spike_cnt <= '0;
    end else begin
      s_out <= 1'b0;
      if (en) begin
        if (rcnt != '0) begin
          // Refractory: leak only, synaptic input is discarded.
          p_q  <= leak_sat;
          rcnt <= rcnt - RW'(1);
        end else if (fire) begin
          s_out <= 1'b1;
          rcnt  <= RW'(REFRAC);
          p_q   <= (RESET_MODE == 0) ? (v_sat - THR_W) : '0;
        end else begin
          p_q <= v_sat;
        end
      end
      // Clear takes priority over a coincident spike.
      if (clr_cnt) begin
        spike_cnt <= '0;
      end else if (en && fire && (spike_cnt != CNT_MAX)) begin
        spike_cnt <= spike_cnt + CNT_W'(1);
      end
    end
  end

  assign p_out  = p_q;
  assign refrac = (rcnt != '0);

endmodule

// File: tb/tb_lif_neuron_multi.sv
// Bench for lif_neuron_multi: three instances (defaults, zero-reset mode,
// 2-bit counter) share stimulus and are checked against an arithmetic model.
module tb_lif_neuron_multi;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              en = 1'b0;
  logic [3:0]        in_spk = '0;
  logic              clr_cnt = 1'b0;
  logic signed [7:0] w[4];
  logic [31:0]       weights;

  logic       s_v[3];
  logic [7:0] p_v[3];
  logic       rf_v[3];
  logic [7:0] sc_v[3];
  logic [1:0] sc2;

  int total = 0;
  int bad = 0;
  bit chk_on = 1'b0;

  int mp[3], mr[3], mc[3];
  bit ms[3];
  int rmode[3] = '{0, 1, 0};
  int cmax[3]  = '{255, 255, 3};

  bit s2_exp_s[7]  = '{1, 0, 0, 1, 0, 0, 1};
  bit s2_exp_rf[7] = '{1, 1, 0, 1, 1, 0, 1};

  assign weights  = {w[3], w[2], w[1], w[0]};
  assign sc_v[2]  = {6'b0, sc2};

  always #5 clk = ~clk;

  lif_neuron_multi u_dut (
    .clk(clk), .rst(rst), .en(en), .in_spk(in_spk), .weights(weights),
    .clr_cnt(clr_cnt), .s_out(s_v[0]), .p_out(p_v[0]), .refrac(rf_v[0]),
    .spike_cnt(sc_v[0])
  );

  lif_neuron_multi #(.RESET_MODE(1)) u_rm1 (
    .clk(clk), .rst(rst), .en(en), .in_spk(in_spk), .weights(weights),
    .clr_cnt(clr_cnt), .s_out(s_v[1]), .p_out(p_v[1]), .refrac(rf_v[1]),
    .spike_cnt(sc_v[1])
  );

  lif_neuron_multi #(.CNT_W(2)) u_cw2 (
    .clk(clk), .rst(rst), .en(en), .in_spk(in_spk), .weights(weights),
    .clr_cnt(clr_cnt), .s_out(s_v[2]), .p_out(p_v[2]), .refrac(rf_v[2]),
    .spike_cnt(sc2)
  );

  function automatic int floor16(input int t);
    if (t >= 0) return t / 16;
    return -((-t + 15) / 16);
  endfunction

  function automatic int clamp8(input int x);
    if (x > 127) return 127;
    if (x < -128) return -128;
    return x;
  endfunction

  // Model: leak 0.75 with floor, threshold 1.0, refractory 2, per-instance reset mode / counter cap.
  always @(posedge clk or posedge rst) begin : model
    int lk, v, syn;
    bit fired;
    if (rst) begin
      for (int k = 0; k < 3; k++) begin
        mp[k] <= 0; mr[k] <= 0; ms[k] <= 1'b0; mc[k] <= 0;
      end
    end else begin
      syn = 0;
      for (int i = 0; i < 4; i++) if (in_spk[i]) syn = syn + int'(w[i]);
      for (int k = 0; k < 3; k++) begin
        fired = 1'b0;
        ms[k] <= 1'b0;
        if (en) begin
          lk = floor16(12 * mp[k]);
          if (mr[k] > 0) begin
            mp[k] <= clamp8(lk);
            mr[k] <= mr[k] - 1;
          end else begin
            v = clamp8(lk + syn);
            if (v >= 16) begin
              fired = 1'b1;
              ms[k] <= 1'b1;
              mr[k] <= 2;
              mp[k] <= (rmode[k] != 0) ? 0 : v - 16;
            end else begin
              mp[k] <= v;
            end
          end
        end
        if (clr_cnt) mc[k] <= 0;
        else if (fired && mc[k] < cmax[k]) mc[k] <= mc[k] + 1;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("cyc_s_out[%0d]", k), int'(s_v[k]), int'(ms[k]));
        chk($sformatf("cyc_p_out[%0d]", k), int'($signed(p_v[k])), mp[k]);
        chk($sformatf("cyc_refrac[%0d]", k), int'(rf_v[k]), int'(mr[k] != 0));
        chk($sformatf("cyc_cnt[%0d]", k), int'(sc_v[k]), mc[k]);
      end
    end
  end

  task automatic tick(input bit e, input logic [3:0] spk, input bit clr = 1'b0);
    @(negedge clk);
    en = e; in_spk = spk; clr_cnt = clr;
    @(posedge clk);
    #1;
    en = 1'b0; clr_cnt = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_p[%0d]", k), int'($signed(p_v[k])), 0);
      chk($sformatf("rst_s[%0d]", k), int'(s_v[k]), 0);
      chk($sformatf("rst_refrac[%0d]", k), int'(rf_v[k]), 0);
      chk($sformatf("rst_cnt[%0d]", k), int'(sc_v[k]), 0);
    end
    @(negedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic set_w(input int a, input int b, input int c, input int d);
    w[0] = 8'(a); w[1] = 8'(b); w[2] = 8'(c); w[3] = 8'(d);
  endtask

  initial begin
    set_w(0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_on = 1'b1;

    // Reset: build state, then async pulse mid-cycle, then idle with random inputs.
    set_w(8, 0, 0, 0);
    tick(1'b1, 4'b0001);
    tick(1'b1, 4'b0001);
    chk("pre_rst_p", int'($signed(p_v[0])), 14);
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_w($urandom_range(0, 255), $urandom_range(0, 255),
            $urandom_range(0, 255), $urandom_range(0, 255));
      tick(1'b0, 4'($urandom_range(0, 15)));
    end
    chk("idle_p", int'($signed(p_v[0])), 0);
    chk("idle_cnt", int'(sc_v[0]), 0);

    // Refractory pacing: spikes on steps 1, 4, 7.
    do_reset();
    set_w(16, 0, 0, 0);
    for (int i = 0; i < 7; i++) begin
      tick(1'b1, 4'b0001);
      chk($sformatf("refr_s_step%0d", i + 1), int'(s_v[0]), int'(s2_exp_s[i]));
      chk($sformatf("refr_rf_step%0d", i + 1), int'(rf_v[0]), int'(s2_exp_rf[i]));
      chk($sformatf("refr_p_step%0d", i + 1), int'($signed(p_v[0])), 0);
    end
    chk("refr_cnt", int'(sc_v[0]), 3);
    chk("refr_model_cnt", mc[0], 3);

    // Sub-threshold integration, both reset modes.
    do_reset();
    set_w(8, 0, 0, 0);
    tick(1'b1, 4'b0001);
    chk("int_p1", int'($signed(p_v[0])), 8);
    tick(1'b1, 4'b0001);
    chk("int_p2", int'($signed(p_v[0])), 14);
    chk("int_model_p2", mp[0], 14);
    tick(1'b1, 4'b0001);
    chk("int_s3", int'(s_v[0]), 1);
    chk("int_p3_sub", int'($signed(p_v[0])), 2);
    chk("int_p3_zero", int'($signed(p_v[1])), 0);
    chk("int_s3_zero", int'(s_v[1]), 1);

    // Saturation: 4*100 clamps to 127, then subtract 16.
    do_reset();
    set_w(100, 100, 100, 100);
    tick(1'b1, 4'b1111);
    chk("sat_s", int'(s_v[0]), 1);
    chk("sat_p", int'($signed(p_v[0])), 111);
    chk("sat_model_p", mp[0], 111);

    // Negative weight and leak with floor rounding.
    do_reset();
    set_w(-128, 0, 0, 0);
    tick(1'b1, 4'b0001);
    chk("neg_p1", int'($signed(p_v[0])), -128);
    chk("neg_s1", int'(s_v[0]), 0);
    tick(1'b1, 4'b0000);
    chk("neg_p2", int'($signed(p_v[0])), -96);
    tick(1'b1, 4'b0000);
    chk("neg_p3", int'($signed(p_v[0])), -72);
    tick(1'b1, 4'b0000);
    chk("neg_p4", int'($signed(p_v[0])), -54);
    tick(1'b1, 4'b0000);
    chk("neg_p5_floor", int'($signed(p_v[0])), -41);
    chk("neg_model_p5", mp[0], -41);

    // Counter saturation, clear on a spike edge, en gating during refractory.
    do_reset();
    set_w(16, 0, 0, 0);
    for (int i = 0; i < 15; i++) tick(1'b1, 4'b0001);
    chk("cnt_sat2", int'(sc_v[2]), 3);
    chk("cnt_wide", int'(sc_v[0]), 5);
    set_w(20, 0, 0, 0);
    tick(1'b1, 4'b0001, 1'b1);
    chk("clr_s", int'(s_v[0]), 1);
    chk("clr_cnt0", int'(sc_v[0]), 0);
    chk("clr_cnt2", int'(sc_v[2]), 0);
    chk("clr_p", int'($signed(p_v[0])), 4);
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 4'b0001);
      chk($sformatf("gate_p%0d", i), int'($signed(p_v[0])), 4);
      chk($sformatf("gate_rf%0d", i), int'(rf_v[0]), 1);
      chk($sformatf("gate_s%0d", i), int'(s_v[0]), 0);
    end
    tick(1'b1, 4'b0001);
    chk("gate_resume_p", int'($signed(p_v[0])), 3);
    chk("gate_resume_rf", int'(rf_v[0]), 1);

    @(negedge clk);
    @(negedge clk);
    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
